// File: rtl/handle_req_arbiter.sv
// handle_req_arbiter: round-robin front end for one shared handle_handler bus.
// Requesters issue ALLOC/FREE/READ/WRITE commands. Each one is expanded into
// handle_handler bus cycles (ALLOC takes two: fetch a free id, then map it).
// Exactly one response is returned per accepted command, with at most one
// command in flight at a time.
module handle_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int HNDL_WIDTH = 15
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [3*NUM_REQ-1:0]           req_cmd,
    input  logic [ADDR_WIDTH*NUM_REQ-1:0]  req_addr,
    input  logic [ADDR_WIDTH*NUM_REQ-1:0]  req_data,
    output logic [2:0]                     hh_op,
    output logic [ADDR_WIDTH-1:0]          hh_address,
    output logic [ADDR_WIDTH-1:0]          hh_data,
    input  logic [ADDR_WIDTH-1:0]          hh_o_address,
    input  logic [ADDR_WIDTH-1:0]          hh_o_data,
    output logic                           resp_valid,
    output logic [$clog2(NUM_REQ)-1:0]     resp_id,
    output logic [ADDR_WIDTH-1:0]          resp_data,
    output logic                           resp_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Id field mask, handle-op region prefix, and the "fetch free id" address.
    localparam logic [ADDR_WIDTH-1:0] ID_MASK = {{(ADDR_WIDTH-HNDL_WIDTH){1'b0}}, {HNDL_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH-1:0] OP_HI   = {{(HNDL_WIDTH+1){1'b1}}, {(ADDR_WIDTH-HNDL_WIDTH-1){1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] OPBASE  = OP_HI | ID_MASK;

    localparam logic [2:0] HH_NOP    = 3'd0;
    localparam logic [2:0] HH_READ   = 3'd1;
    localparam logic [2:0] HH_WRITE  = 3'd2;
    localparam logic [2:0] CMD_ALLOC = 3'd0;
    localparam logic [2:0] CMD_FREE  = 3'd1;
    localparam logic [2:0] CMD_READ  = 3'd2;
    localparam logic [2:0] CMD_WRITE = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_MAP   = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Handle-op address for an id; bits above the id field are discarded.
    function automatic logic [ADDR_WIDTH-1:0] op_addr(input logic [ADDR_WIDTH-1:0] id);
        return OP_HI | (id & ID_MASK);
    endfunction

    // True when the address falls inside the reserved handle-op region.
    function automatic logic in_op_region(input logic [ADDR_WIDTH-1:0] addr);
        return (addr & OP_HI) == OP_HI;
    endfunction

    state_t                 state_r, state_n;
    logic [IDX_W-1:0]       rr_ptr_r, rr_ptr_n;
    logic [2:0]             cmd_r, cmd_n;
    logic [ADDR_WIDTH-1:0]  base_r, base_n;
    logic [IDX_W-1:0]       idx_r, idx_n;
    logic [ADDR_WIDTH-1:0]  id_r, id_n;

    logic [2:0]             hh_op_n;
    logic [ADDR_WIDTH-1:0]  hh_address_n, hh_data_n;
    logic                   resp_valid_n, resp_err_n;
    logic [IDX_W-1:0]       resp_id_n;
    logic [ADDR_WIDTH-1:0]  resp_data_n;

    logic [2:0]             cmd_a  [NUM_REQ];
    logic [ADDR_WIDTH-1:0]  addr_a [NUM_REQ];
    logic [ADDR_WIDTH-1:0]  data_a [NUM_REQ];

    logic                   win_found_s;
    logic [IDX_W-1:0]       win_idx_s;
    logic [2:0]             win_cmd_s;
    logic [ADDR_WIDTH-1:0]  win_addr_s, win_data_s;
    logic                   precheck_err_s;

    // Split the packed per-requester buses into indexable arrays.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cmd_a[i]  = req_cmd[3*i +: 3];
            addr_a[i] = req_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
            data_a[i] = req_data[ADDR_WIDTH*i +: ADDR_WIDTH];
        end
    end

    // Round-robin search: first valid requester at or after rr_ptr, with wrap.
    always_comb begin
        logic [IDX_W-1:0] cand;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr_r) + i) % NUM_REQ);
            if (!win_found_s && req_valid[cand]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand;
            end else begin
                win_found_s = win_found_s;
            end
        end
        win_cmd_s  = cmd_a[win_idx_s];
        win_addr_s = addr_a[win_idx_s];
        win_data_s = data_a[win_idx_s];
    end

    // Commands that can be rejected without touching the handle_handler bus.
    always_comb begin
        case (win_cmd_s)
            CMD_ALLOC: precheck_err_s = (win_data_s == {ADDR_WIDTH{1'b0}});
            CMD_FREE:  precheck_err_s = ((win_addr_s & ID_MASK) == ID_MASK);
            CMD_READ,
            CMD_WRITE: precheck_err_s = in_op_region(win_addr_s);
            default:   precheck_err_s = 1'b1;
        endcase
    end

    // Accept strobe: one-hot to the winner, only while idle.
    always_comb begin
        req_ready = '0;
        if (state_r == ST_IDLE && win_found_s) begin
            req_ready[win_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Next state plus the bus/response values to be registered for the next cycle.
    always_comb begin
        state_n      = state_r;
        rr_ptr_n     = rr_ptr_r;
        cmd_n        = cmd_r;
        base_n       = base_r;
        idx_n        = idx_r;
        id_n         = id_r;
        hh_op_n      = HH_NOP;
        hh_address_n = '0;
        hh_data_n    = '0;
        resp_valid_n = 1'b0;
        resp_id_n    = '0;
        resp_data_n  = '0;
        resp_err_n   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    cmd_n    = win_cmd_s;
                    base_n   = win_data_s;
                    idx_n    = win_idx_s;
                    rr_ptr_n = IDX_W'((int'(win_idx_s) + 1) % NUM_REQ);
                    if (precheck_err_s) begin
                        state_n      = ST_RESP;
                        resp_valid_n = 1'b1;
                        resp_id_n    = win_idx_s;
                        resp_err_n   = 1'b1;
                    end else begin
                        state_n = ST_ISSUE;
                        case (win_cmd_s)
                            CMD_ALLOC: begin
                                hh_op_n      = HH_READ;
                                hh_address_n = OPBASE;
                            end
                            CMD_FREE: begin
                                hh_op_n      = HH_WRITE;
                                hh_address_n = op_addr(win_addr_s);
                            end
                            CMD_READ: begin
                                hh_op_n      = HH_READ;
                                hh_address_n = win_addr_s;
                            end
                            CMD_WRITE: begin
                                hh_op_n      = HH_WRITE;
                                hh_address_n = win_addr_s;
                            end
                            default: hh_op_n = HH_NOP;
                        endcase
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                resp_id_n = idx_r;
                case (cmd_r)
                    CMD_ALLOC: begin
                        if ((hh_o_data & ID_MASK) == ID_MASK) begin
                            // all-ones id means the table is full
                            state_n      = ST_RESP;
                            resp_valid_n = 1'b1;
                            resp_err_n   = 1'b1;
                        end else begin
                            state_n      = ST_MAP;
                            id_n         = hh_o_data & ID_MASK;
                            hh_op_n      = HH_WRITE;
                            hh_address_n = op_addr(hh_o_data);
                            hh_data_n    = base_r;
                        end
                    end
                    CMD_FREE: begin
                        state_n      = ST_RESP;
                        resp_valid_n = 1'b1;
                    end
                    CMD_READ,
                    CMD_WRITE: begin
                        state_n      = ST_RESP;
                        resp_valid_n = 1'b1;
                        resp_data_n  = hh_o_address;
                    end
                    default: begin
                        state_n      = ST_RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                    end
                endcase
            end
            ST_MAP: begin
                state_n      = ST_RESP;
                resp_valid_n = 1'b1;
                resp_id_n    = idx_r;
                resp_data_n  = id_r;
            end
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // State, command context and registered bus/response outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= '0;
            cmd_r      <= 3'd0;
            base_r     <= '0;
            idx_r      <= '0;
            id_r       <= '0;
            hh_op      <= HH_NOP;
            hh_address <= '0;
            hh_data    <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            state_r    <= state_n;
            rr_ptr_r   <= rr_ptr_n;
            cmd_r      <= cmd_n;
            base_r     <= base_n;
            idx_r      <= idx_n;
            id_r       <= id_n;
            hh_op      <= hh_op_n;
            hh_address <= hh_address_n;
            hh_data    <= hh_data_n;
            resp_valid <= resp_valid_n;
            resp_id    <= resp_id_n;
            resp_data  <= resp_data_n;
            resp_err   <= resp_err_n;
        end
    end

endmodule

// File: tb/tb_handle_req_arbiter.sv
// Directed bench for handle_req_arbiter with a small handle_handler model.
module tb_handle_req_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid, req_ready;
    logic [11:0]   req_cmd;
    logic [255:0]  req_addr, req_data;
    logic [2:0]    hh_op;
    logic [63:0]   hh_address, hh_data, hh_o_address, hh_o_data;
    logic          resp_valid, resp_err;
    logic [1:0]    resp_id;
    logic [63:0]   resp_data;

    // handle_handler model state
    logic [7:0]    mapped;
    logic [63:0]   base_tab [8];
    logic          full;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0]  s_op    [5];
    logic [63:0] s_addr  [5];
    logic [63:0] s_data  [5];
    logic [63:0] s_rdata [5];
    logic        s_rv    [5];
    logic        s_err   [5];
    logic [1:0]  s_rid   [5];

    handle_req_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(64), .HNDL_WIDTH(15)) dut (
        .i_clock(clk), .i_reset(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_data(req_data),
        .hh_op(hh_op), .hh_address(hh_address), .hh_data(hh_data),
        .hh_o_address(hh_o_address), .hh_o_data(hh_o_data),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Model: lowest unmapped id, or all-ones when forced full
    always_comb begin
        hh_o_data = 64'h7FFF;
        if (!full) begin
            for (int i = 7; i >= 0; i--) begin
                if (!mapped[i]) hh_o_data = 64'(i);
            end
        end
    end

    // Model: translate handle addresses (MSB set), pass others through
    always_comb begin
        if (hh_address[63]) hh_o_address = base_tab[hh_address[50:48]] + {16'h0, hh_address[47:0]};
        else                hh_o_address = hh_address;
    end

    // Model: mapping table updated by handle-op writes
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mapped <= 8'h0;
            for (int i = 0; i < 8; i++) base_tab[i] <= 64'h0;
        end else if (hh_op == 3'd2 && hh_address[63:48] == 16'hFFFF) begin
            if (hh_data != 64'h0) begin
                mapped[hh_address[2:0]]   <= 1'b1;
                base_tab[hh_address[2:0]] <= hh_data;
            end else begin
                mapped[hh_address[2:0]] <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap(input int c);
        s_op[c]    = hh_op;
        s_addr[c]  = hh_address;
        s_data[c]  = hh_data;
        s_rdata[c] = resp_data;
        s_rv[c]    = resp_valid;
        s_err[c]   = resp_err;
        s_rid[c]   = resp_id;
    endtask

    // Present one command, check the ready pulse, record cycles 0..4 after grant
    task automatic do_cmd(input int idx, input logic [2:0] cmd, input logic [63:0] addr, input logic [63:0] data);
        logic [3:0] exp_rdy;
        @(negedge clk);
        req_valid[idx]        = 1'b1;
        req_cmd[3*idx +: 3]   = cmd;
        req_addr[64*idx +: 64] = addr;
        req_data[64*idx +: 64] = data;
        exp_rdy = 4'b0001 << idx;
        #1;
        check("ready", 64'(req_ready), 64'(exp_rdy));
        snap(0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) req_valid[idx] = 1'b0;
            #1;
            snap(c);
        end
    endtask

    task automatic expect_resp(input string tag, input int lat, input int id, input logic [63:0] data, input logic err);
        int got_lat;
        got_lat = 0;
        for (int c = 4; c >= 1; c--) if (s_rv[c]) got_lat = c;
        check({tag, "_lat"}, 64'(got_lat), 64'(lat));
        if (got_lat != 0) begin
            check({tag, "_id"},   64'(s_rid[got_lat]), 64'(id));
            check({tag, "_data"}, s_rdata[got_lat], data);
            check({tag, "_err"},  64'(s_err[got_lat]), 64'(err));
        end
    endtask

    // Several simultaneous READ requesters; check grant order, spacing and responses
    task automatic multi(input logic [3:0] mask, input int n, input int e0, input int e1, input int e2, input int e3);
        int exp_o [4];
        int got, nresp, last_t, drop, k;
        exp_o = '{e0, e1, e2, e3};
        got = 0; nresp = 0; last_t = 0; drop = -1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                req_valid[i]         = 1'b1;
                req_cmd[3*i +: 3]    = 3'd2;
                req_addr[64*i +: 64] = 64'h100 + 64'(i);
            end
        end
        for (int t = 0; t < 40 && (got < n || nresp < n); t++) begin
            #1;
            if (resp_valid && nresp < n) begin
                check("rr_resp_id", 64'(resp_id), 64'(exp_o[nresp]));
                check("rr_resp_data", resp_data, 64'h100 + 64'(exp_o[nresp]));
                check("rr_resp_lat", 64'(t - last_t), 64'd2);
                nresp++;
            end
            if (req_ready != 4'b0000) begin
                k = 0;
                for (int i = 0; i < 4; i++) if (req_ready[i]) k = i;
                check("rr_onehot", 64'($countones(req_ready)), 64'd1);
                if (got < n) check("rr_grant", 64'(k), 64'(exp_o[got]));
                if (got > 0) check("rr_spacing", 64'(t - last_t), 64'd3);
                last_t = t;
                got++;
                drop = k;
            end
            @(negedge clk);
            if (drop >= 0) begin
                req_valid[drop] = 1'b0;
                drop = -1;
            end
        end
        check("rr_grants", 64'(got), 64'(n));
        check("rr_resps", 64'(nresp), 64'(n));
    endtask

    // Bound on total run time
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    logic [2:0]  v_cmd  [4] = '{3'd5, 3'd0, 3'd2, 3'd1};
    logic [63:0] v_addr [4] = '{64'h0, 64'h0, 64'hFFFF_0000_0000_0003, 64'h7FFF};
    logic [63:0] v_data [4] = '{64'h0, 64'h0, 64'h0, 64'h0};

    initial begin
        int seen;
        logic [2:0] op_or;
        rst = 1'b1; req_valid = 4'h0; req_cmd = '0; req_addr = '0; req_data = '0; full = 1'b0;
        #12;
        check("rst_hh_op", 64'(hh_op), 64'd0);
        check("rst_hh_addr", hh_address, 64'h0);
        check("rst_hh_data", hh_data, 64'h0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", resp_data, 64'h0);
        check("rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Round-robin order from reset, then 0 and 2 with pointer back at 0
        multi(4'b1111, 4, 0, 1, 2, 3);
        multi(4'b0101, 2, 0, 2, 0, 0);

        // ALLOC on a fresh table: id 0
        do_cmd(0, 3'd0, 64'h0, 64'h10);
        check("a0_issue_op", 64'(s_op[1]), 64'd1);
        check("a0_issue_addr", s_addr[1], 64'hFFFF_0000_0000_7FFF);
        check("a0_issue_data", s_data[1], 64'h0);
        check("a0_map_op", 64'(s_op[2]), 64'd2);
        check("a0_map_addr", s_addr[2], 64'hFFFF_0000_0000_0000);
        check("a0_map_data", s_data[2], 64'h10);
        check("a0_idle_op", 64'(s_op[0]), 64'd0);
        expect_resp("a0", 3, 0, 64'h0, 1'b0);

        // Two more ALLOCs: id 1 -> 0x20, id 2 -> 0x10
        do_cmd(1, 3'd0, 64'h0, 64'h20);
        expect_resp("a1", 3, 1, 64'h1, 1'b0);
        do_cmd(2, 3'd0, 64'h0, 64'h10);
        check("a2_map_addr", s_addr[2], 64'hFFFF_0000_0000_0002);
        expect_resp("a2", 3, 2, 64'h2, 1'b0);

        // Handle READ translates through id 2
        do_cmd(3, 3'd2, 64'h8002_0000_0000_0001, 64'h0);
        check("rd_op", 64'(s_op[1]), 64'd1);
        check("rd_addr", s_addr[1], 64'h8002_0000_0000_0001);
        expect_resp("rd", 2, 3, 64'h11, 1'b0);

        // Plain WRITE passes through
        do_cmd(1, 3'd3, 64'h1234, 64'h0);
        check("wr_op", 64'(s_op[1]), 64'd2);
        check("wr_addr", s_addr[1], 64'h1234);
        expect_resp("wr", 2, 1, 64'h1234, 1'b0);

        // FREE id 2
        do_cmd(0, 3'd1, 64'h2, 64'h0);
        check("fr_op", 64'(s_op[1]), 64'd2);
        check("fr_addr", s_addr[1], 64'hFFFF_0000_0000_0002);
        check("fr_data", s_data[1], 64'h0);
        expect_resp("fr", 2, 0, 64'h0, 1'b0);

        // ALLOC with the table full: no MAP cycle
        full = 1'b1;
        do_cmd(1, 3'd0, 64'h0, 64'h40);
        check("full_issue_op", 64'(s_op[1]), 64'd1);
        check("full_nomap_op", 64'(s_op[2]), 64'd0);
        expect_resp("full", 2, 1, 64'h0, 1'b1);
        full = 1'b0;

        // Pre-check rejects: illegal cmd, ALLOC base 0, READ in op region, FREE all-ones
        for (int v = 0; v < 4; v++) begin
            do_cmd(v, v_cmd[v], v_addr[v], v_data[v]);
            op_or = 3'd0;
            for (int c = 0; c <= 4; c++) op_or = op_or | s_op[c];
            check("pre_bus_idle", 64'(op_or), 64'd0);
            expect_resp("pre", 1, v, 64'h0, 1'b1);
        end

        // Reset during MAP of an ALLOC from requester 2
        @(negedge clk);
        req_valid[2] = 1'b1; req_cmd[8:6] = 3'd0; req_data[191:128] = 64'h50;
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(negedge clk);
        #1;
        check("mr_map_op", 64'(hh_op), 64'd2);
        #1 rst = 1'b1;
        #1;
        check("mr_rst_op", 64'(hh_op), 64'd0);
        check("mr_rst_addr", hh_address, 64'h0);
        check("mr_rst_resp", 64'(resp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (resp_valid) seen++;
            @(negedge clk);
        end
        check("mr_no_resp", 64'(seen), 64'd0);
        multi(4'b1001, 2, 0, 3, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/handle_req_arbiter.md
Name: handle_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one handle_handler command bus between NUM_REQ requesters.
- Requesters issue high-level commands: ALLOC, FREE, READ, WRITE. The block expands them into handle_handler bus cycles, including the two-step ALLOC (fetch free id, then write its mapping).
- Returns one response per command on a shared response bus.
- Sits between CPU-side request ports and handle_handler.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ADDR_WIDTH, 64, address/data width, matches handle_handler
HNDL_WIDTH, 15, handle id width; id all-ones is reserved

Ports:
i_clock  in  1  clock; all state updates on posedge
i_reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request pending
req_ready  out  NUM_REQ  one-hot accept; combinational, high only in IDLE for the granted requester
req_cmd  in  3*NUM_REQ  packed commands: 0 ALLOC, 1 FREE, 2 READ, 3 WRITE, 4-7 illegal
req_addr  in  ADDR_WIDTH*NUM_REQ  ALLOC: unused; FREE: id in [HNDL_WIDTH-1:0]; READ/WRITE: handle address
req_data  in  ADDR_WIDTH*NUM_REQ  ALLOC: base address; WRITE: unused here (data path external); others: unused
hh_op  out  3  handle_handler op (0 NOP, 1 READ, 2 WRITE)
hh_address  out  ADDR_WIDTH  handle_handler i_address
hh_data  out  ADDR_WIDTH  handle_handler i_data
hh_o_address  in  ADDR_WIDTH  translated address from handle_handler
hh_o_data  in  ADDR_WIDTH  handle_handler o_data; free id in [HNDL_WIDTH-1:0]
resp_valid  out  1  one-cycle response strobe
resp_id  out  $clog2(NUM_REQ)  requester index of the response
resp_data  out  ADDR_WIDTH  response payload
resp_err  out  1  command failed

Behaviour:
Reset values (async):
- state=IDLE, rr_ptr=0
- hh_op=0, hh_address=0, hh_data=0
- resp_valid=0, resp_id=0, resp_data=0, resp_err=0

Constants:
- OPBASE = top HNDL_WIDTH+1 bits all ones, low HNDL_WIDTH bits all ones.
- OP(id) = top HNDL_WIDTH+1 bits ones, low bits = id.
- "Handle-op region" = top HNDL_WIDTH+1 address bits all ones.

States: IDLE, ISSUE, MAP, RESP.

IDLE:
- Winner = first asserted req_valid searching from rr_ptr upward with wrap.
- req_ready[winner]=1; the handshake completes on that edge.
- At that edge: latch cmd/addr/data/index, rr_ptr<=(winner+1) mod NUM_REQ.
- Pre-check, which bypasses the bus (go to RESP with err=1, data=0): illegal cmd; ALLOC with base==0; FREE with id all-ones; READ/WRITE with address in the handle-op region.
- Otherwise go to ISSUE.
- No req_valid: stay in IDLE, req_ready=0.

ISSUE (one cycle):
- Bus registered, driven for this whole cycle:
  - ALLOC: READ, OPBASE, data 0.
  - FREE: WRITE, OP(id), data 0.
  - READ: READ, req_addr.
  - WRITE: WRITE, req_addr.
- At cycle end, sample hh_o_data / hh_o_address.
- ALLOC: if sampled id==all-ones (table full), go to RESP with err=1, data=0. Otherwise latch id and go to MAP.

MAP (ALLOC only, one cycle):
- Drive WRITE, OP(id), data=base. Then go to RESP.

RESP (one cycle):
- resp_valid=1; resp_id=latched index.
- resp_data: ALLOC gives the id zero-extended; FREE gives 0; READ/WRITE give the sampled hh_o_address.
- Then go to IDLE.
- Requesters must accept the response; there is no backpressure.

Bus idle rule: in IDLE and RESP, hh_op=0 and hh_address=hh_data=0.

Latency from acceptance edge to resp_valid cycle:
- 2 cycles for FREE/READ/WRITE.
- 3 cycles for ALLOC.
- 1 cycle for pre-check errors.

Throughput: at most one outstanding command. The next grant occurs in the IDLE cycle after RESP.

Edge cases:
- req_valid dropped before grant: ignored, no state change.
- Reset mid-command: bus returns to NOP immediately; the command is lost with no response; rr_ptr returns to 0.
- Non-handle READ/WRITE address (MSB 0): passed through and the result returned, err=0.

Test Plan:
1. Reset, then req 0 ALLOC base=0x10 with a fresh handle_handler model. Required: req_ready[0] pulse; ISSUE shows hh_op=1, hh_address=0xFFFF00000000_7FFF; MAP shows hh_op=2, address 0xFFFF000000000000+id, data 0x10; resp_valid 3 cycles after acceptance, resp_id=0, resp_data=id, err=0.
2. Requesters 0-3 all assert READ simultaneously from reset. Required grant order 0,1,2,3. Then re-assert 0 and 2 with rr_ptr=0: order 0,2. Check no grant while busy.
3. Id 2 mapped to 0x10, READ 0x8002_0000_0000_0001. Required: hh_op=1 in ISSUE, resp_data=0x11, err=0, latency 2.
4. FREE id 2. Required: bus WRITE 0xFFFF_0000_0000_0002 data 0, resp_data 0. Then ALLOC with model reporting all-ones: err=1, data 0, no MAP cycle.
5. Illegal cmd 5; ALLOC base 0; READ 0xFFFF_0000_0000_0003. Required: each gives resp_valid 1 cycle after acceptance, err=1, hh_op stays 0 throughout.
6. Assert i_reset asynchronously during MAP of an ALLOC. Required: hh_op=0 and resp_valid=0 immediately; no response issued; next grant starts from requester 0.
